// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each transaction is ACCESS then COMPLETE, so back-to-back traffic moves one per two cycles.
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [11:0] addr0,
  input  logic [3:0]  wdata0,
  output logic        gnt0,
  output logic        done0,
  output logic [3:0]  rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [11:0] addr1,
  input  logic [3:0]  wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic [3:0]  rdata1,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [3:0]  ram_wdata,
  input  logic [3:0]  ram_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        last_grant;
  logic        owner;
  logic        lat_we;
  logic [11:0] lat_addr;
  logic [3:0]  lat_wdata;
  logic        open;
  logic        accept;
  logic        in_access;

  // Grants only while a new transaction may start; a tie goes to
  // the port that did not own the previous transaction.
  assign open   = reset && (state == IDLE || state == COMPLETE);
  assign gnt0   = open && req0 && (!req1 || last_grant);
  assign gnt1   = open && req1 && (!req0 || !last_grant);
  assign accept = (req0 && gnt0) || (req1 && gnt1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = accept ? ACCESS : IDLE;
      ACCESS:   state_nx = COMPLETE;
      COMPLETE: state_nx = accept ? ACCESS : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_access = (state == ACCESS);
    ram_cs    = in_access;
    ram_we    = in_access && lat_we;
    ram_addr  = in_access ? lat_addr : 12'h000;
    ram_wdata = (in_access && lat_we) ? lat_wdata : 4'h0;
    done0     = (state == COMPLETE) && !owner;
    done1     = (state == COMPLETE) && owner;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 12'h000;
      lat_wdata  <= 4'h0;
      rdata0     <= 4'h0;
      rdata1     <= 4'h0;
    end else begin
      if (accept) begin
        owner     <= gnt1;
        lat_we    <= gnt1 ? we1 : we0;
        lat_addr  <= gnt1 ? addr1 : addr0;
        lat_wdata <= gnt1 ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        last_grant <= owner;
        if (!lat_we) begin
          if (owner) begin
            rdata1 <= ram_rdata;
          end else begin
            rdata0 <= ram_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: cycle table plus a sustained
// contention sequence checked against hand-derived expectations.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [3:0]  wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [3:0]  rdata0, rdata1;
  logic        ram_cs, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wdata, ram_rdata;

  int n_chk;
  int n_fail;

  ram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .done0     (done0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .done1     (done1),
    .rdata1    (rdata1),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fi = {reset, req0, we0, req1, we1}
  // fo = {gnt0, gnt1, done0, done1, ram_cs, ram_we}
  typedef struct {
    logic [4:0]  fi;
    logic [11:0] a0;
    logic [3:0]  d0;
    logic [11:0] a1;
    logic [3:0]  d1;
    logic [3:0]  rr;
    logic [5:0]  fo;
    logic [3:0]  rd0;
    logic [3:0]  rd1;
    logic [11:0] ad;
    logic [3:0]  wd;
  } vec_t;

  vec_t tv [28];

  task automatic chk(input string nm, input int row,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic check_outs(input int row, input logic [5:0] fo,
                            input logic [3:0] rd0, input logic [3:0] rd1,
                            input logic [11:0] ad, input logic [3:0] wd);
    chk("flags", row,
        {10'b0, gnt0, gnt1, done0, done1, ram_cs, ram_we},
        {10'b0, fo});
    chk("rdata", row, {8'b0, rdata0, rdata1}, {8'b0, rd0, rd1});
    chk("ram_bus", row, {ram_addr, ram_wdata}, {ad, wd});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    tv[0]  = '{5'b01100, 12'h123, 4'hA, 12'h000, 4'h0, 4'h0, 6'b000000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[1]  = '{5'b11100, 12'h123, 4'hA, 12'h000, 4'h0, 4'h0, 6'b100000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[2]  = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000011, 4'h0, 4'h0, 12'h123, 4'hA};
    tv[3]  = '{5'b11000, 12'h123, 4'h0, 12'h000, 4'h0, 4'h0, 6'b101000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[4]  = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'hA, 6'b000010, 4'h0, 4'h0, 12'h123, 4'h0};
    tv[5]  = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b001000, 4'hA, 4'h0, 12'h000, 4'h0};
    tv[6]  = '{5'b00000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000000, 4'hA, 4'h0, 12'h000, 4'h0};
    tv[7]  = '{5'b11111, 12'h010, 4'h3, 12'h020, 4'h4, 4'h0, 6'b100000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[8]  = '{5'b10011, 12'h000, 4'h0, 12'h020, 4'h4, 4'h0, 6'b000011, 4'h0, 4'h0, 12'h010, 4'h3};
    tv[9]  = '{5'b11011, 12'h010, 4'h0, 12'h020, 4'h4, 4'h0, 6'b011000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[10] = '{5'b11000, 12'h010, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000011, 4'h0, 4'h0, 12'h020, 4'h4};
    tv[11] = '{5'b11000, 12'h010, 4'h0, 12'h000, 4'h0, 4'h0, 6'b100100, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[12] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h3, 6'b000010, 4'h0, 4'h0, 12'h010, 4'h0};
    tv[13] = '{5'b10010, 12'h000, 4'h0, 12'hFFF, 4'h0, 4'h0, 6'b011000, 4'h3, 4'h0, 12'h000, 4'h0};
    tv[14] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h5, 6'b000010, 4'h3, 4'h0, 12'hFFF, 4'h0};
    tv[15] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000100, 4'h3, 4'h5, 12'h000, 4'h0};
    tv[16] = '{5'b11000, 12'h040, 4'h0, 12'h000, 4'h0, 4'h0, 6'b100000, 4'h3, 4'h5, 12'h000, 4'h0};
    tv[17] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h7, 6'b000010, 4'h3, 4'h5, 12'h040, 4'h0};
    tv[18] = '{5'b11100, 12'h040, 4'h9, 12'h000, 4'h0, 4'h0, 6'b101000, 4'h7, 4'h5, 12'h000, 4'h0};
    tv[19] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'hE, 6'b000011, 4'h7, 4'h5, 12'h040, 4'h9};
    tv[20] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b001000, 4'h7, 4'h5, 12'h000, 4'h0};
    tv[21] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000000, 4'h7, 4'h5, 12'h000, 4'h0};
    tv[22] = '{5'b00000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000000, 4'h7, 4'h5, 12'h000, 4'h0};
    tv[23] = '{5'b10010, 12'h000, 4'h0, 12'h0AB, 4'h0, 4'h0, 6'b010000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[24] = '{5'b00000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h6, 6'b000010, 4'h0, 4'h0, 12'h0AB, 4'h0};
    tv[25] = '{5'b10010, 12'h000, 4'h0, 12'h0AB, 4'h0, 4'h0, 6'b010000, 4'h0, 4'h0, 12'h000, 4'h0};
    tv[26] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h6, 6'b000010, 4'h0, 4'h0, 12'h0AB, 4'h0};
    tv[27] = '{5'b10000, 12'h000, 4'h0, 12'h000, 4'h0, 4'h0, 6'b000100, 4'h0, 4'h6, 12'h000, 4'h0};

    reset     = 1'b0;
    req0      = 1'b0;
    we0       = 1'b0;
    addr0     = 12'h000;
    wdata0    = 4'h0;
    req1      = 1'b0;
    we1       = 1'b0;
    addr1     = 12'h000;
    wdata1    = 4'h0;
    ram_rdata = 4'h0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      {reset, req0, we0, req1, we1} = tv[i].fi;
      addr0     = tv[i].a0;
      wdata0    = tv[i].d0;
      addr1     = tv[i].a1;
      wdata1    = tv[i].d1;
      ram_rdata = tv[i].rr;
      #1;
      check_outs(i, tv[i].fo, tv[i].rd0, tv[i].rd1, tv[i].ad, tv[i].wd);
      @(posedge clk);
      #1;
    end

    // Sustained contention: port 1 owned last, so port 0 leads.
    for (int i = 0; i < 17; i++) begin
      logic [5:0]  ef;
      logic [11:0] ead;
      int          cur;
      int          prv;
      reset     = 1'b1;
      req0      = (i < 16);
      req1      = (i < 16);
      we0       = 1'b0;
      we1       = 1'b0;
      addr0     = 12'h100;
      addr1     = 12'h200;
      ram_rdata = 4'h0;
      #1;
      ef  = 6'b000000;
      ead = 12'h000;
      if (i % 2 == 0) begin
        cur = (i / 2) % 2;
        prv = ((i / 2) + 1) % 2;
        if (i < 16) begin
          ef[5] = (cur == 0);
          ef[4] = (cur == 1);
        end
        if (i >= 2) begin
          ef[3] = (prv == 0);
          ef[2] = (prv == 1);
        end
      end else begin
        cur   = ((i - 1) / 2) % 2;
        ef[1] = 1'b1;
        ead   = (cur == 1) ? 12'h200 : 12'h100;
      end
      chk("rr_flags", 100 + i,
          {10'b0, gnt0, gnt1, done0, done1, ram_cs, ram_we},
          {10'b0, ef});
      chk("rr_addr", 100 + i, {ram_addr, ram_wdata}, {ead, 4'h0});
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
- req0  input  1  port 0 (CPU) access request.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  12  port 0 RAM address.
- wdata0  input  4  port 0 write data.
- gnt0  output  1  port 0 request accepted this cycle (combinational).
- done0  output  1  port 0 transaction complete (one-cycle pulse).
- rdata0  output  4  port 0 read data, registered.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1  same widths and meanings as port 0, for port 1 (loader/debug).
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_addr  output  12  RAM address.
- ram_wdata  output  4  RAM write data, driven only when ram_cs=1 and ram_we=1.
- ram_rdata  input  4  RAM read data, valid in the same cycle as ram_cs=1 and ram_we=0.

Function
REQ-002 SHALL implement a three-state FSM:
- IDLE: no RAM access.
- ACCESS: RAM is driven from the latched request.
- COMPLETE: done is asserted for the owning port.
REQ-003 SHALL accept requests only in IDLE or COMPLETE. A request is accepted on an edge where reqN=1 and gntN=1.
REQ-004 SHALL never assert gnt0 and gnt1 in the same cycle, and SHALL hold both at 0 in ACCESS.
REQ-005 SHALL arbitrate as follows:
- Only one port requesting: that port is granted.
- Both ports requesting: the port not granted last is granted (round-robin, last_grant register).
REQ-006 On acceptance SHALL latch addrN, weN, wdataN and the owner id. The FSM SHALL then go to ACCESS; requester inputs are don't-care after acceptance.
REQ-007 In ACCESS SHALL:
- drive ram_cs=1 and ram_we, ram_addr, ram_wdata from the latched values;
- update last_grant to the owner;
- on a read, capture ram_rdata into rdata of the owner at the end of the cycle.
Then the FSM SHALL go to COMPLETE.
REQ-008 In COMPLETE SHALL pulse done of the owner for exactly one cycle. rdataN SHALL be unchanged after a write and SHALL hold its value until the next read completes for that port.
REQ-009 From COMPLETE SHALL go to ACCESS if a request is accepted in that cycle, else to IDLE.
REQ-010 Latency SHALL be: acceptance edge at cycle T, ram_cs=1 in T+1, doneN=1 in T+2. Back-to-back throughput SHALL be one transaction per 2 cycles.
REQ-011 Outside ACCESS SHALL drive ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-012 Address and data SHALL pass through unmodified; no wrap or arithmetic is applied. Address 0xFFF SHALL be legal.
REQ-013 Under continuous contention, no port SHALL wait longer than one other transaction.

Reset
REQ-014 While reset=0 at a rising edge, the block SHALL enter IDLE and set:
- last_grant=1, so port 0 wins the first contention;
- rdata0=rdata1=0, done0=done1=0;
- RAM outputs to 0.
REQ-015 Reset asserted during ACCESS or COMPLETE SHALL abandon the transaction. No done pulse and no rdata update SHALL follow. RAM write effects already issued are not rolled back.
REQ-016 In a cycle with reset=0, gnt0 and gnt1 SHALL be 0.

Verification
REQ-017 Single write then read:
- port 0 writes 0xA to 0x123 -> ram_cs=1, ram_we=1, ram_addr=0x123, ram_wdata=0xA at T+1; done0 at T+2.
- port 0 reads 0x123 -> rdata0=0xA with done0.
REQ-018 Contention from reset: req0=req1=1 in the same cycle -> gnt0 first; gnt1 in port 0's COMPLETE cycle; done1 two cycles later.
REQ-019 Sustained contention for 8 transactions -> grants alternate 0,1,0,1...; ram_cs is high every other cycle; no gap longer than 1 cycle between transactions.
REQ-020 Read isolation: port 1 reads 0xFFF holding 0x5 while rdata0=0x3 -> rdata1=0x5; rdata0 stays 0x3; done0 stays 0.
REQ-021 Reset in ACCESS: reset=0 for 1 cycle during port 1's ACCESS -> no done1; rdata1 unchanged; next req1 is granted from IDLE.
REQ-022 Write does not disturb read data: port 0 write following a port 0 read of 0x7 -> rdata0 stays 0x7 after done0.
